// File: rtl/sequence_input_collector.sv
// sequence_input_collector: collects multi-bit player symbols, checks them against a latched pattern, reports result/timeout
module sequence_input_collector #(
    parameter int SYM_W       = 1,
    parameter int MAX_LEN     = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int EARLY_ABORT = 1,
    parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic [LEN_W-1:0]         i_length,
    input  logic [MAX_LEN*SYM_W-1:0] i_pattern,
    input  logic                     i_in_valid,
    input  logic [SYM_W-1:0]         i_in_sym,
    output logic                     o_in_ready,
    output logic [MAX_LEN*SYM_W-1:0] o_user_guess,
    output logic [LEN_W-1:0]         o_guess_cnt,
    output logic                     o_received_input,
    output logic                     o_is_equal,
    output logic                     o_timed_out,
    output logic [LEN_W-1:0]         o_err_idx
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    typedef enum logic [1:0] {IDLE, COLLECT, DONE, HOLD} state_t;
    state_t                   r_state, w_next;
    logic [MAX_LEN*SYM_W-1:0] r_shadow, r_guess;
    logic [LEN_W-1:0]         r_len, r_cnt, r_err;
    logic [TW-1:0]            r_timer;
    logic                     r_eq, r_to, r_wrong;
    logic [SYM_W-1:0]         w_exp;
    logic [LEN_W-1:0]         w_len;
    logic                     w_acc, w_match, w_last, w_tout, w_abort;
    always_comb begin
        w_exp = '0;
        for (int k = 0; k < MAX_LEN; k++)
            if (r_cnt == LEN_W'(k)) w_exp = r_shadow[k*SYM_W +: SYM_W];
        w_len   = (i_length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_length;
        // en dropping mid-round cancels it, so no symbol is taken in that cycle either
        w_acc   = (r_state == COLLECT) && i_en && i_in_valid;
        w_match = (i_in_sym == w_exp);
        w_last  = ((r_cnt + 1'b1) == r_len);
        w_abort = (EARLY_ABORT != 0) && !w_match;
        w_tout  = (TIMEOUT_CYC != 0) && (r_timer == TW'(TIMEOUT_CYC - 1));
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (i_en) w_next = (w_len == '0) ? DONE : COLLECT;
            COLLECT: if (!i_en) w_next = IDLE;
                     else if (w_acc ? (w_last || w_abort) : w_tout) w_next = DONE;
            DONE:    w_next = HOLD;
            HOLD:    if (!i_en) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (i_clr) w_next = IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || i_clr) begin
            r_shadow <= '0;
            r_guess  <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_err    <= '0;
            r_timer  <= '0;
            r_eq     <= 1'b0;
            r_to     <= 1'b0;
            r_wrong  <= 1'b0;
        end else if (r_state == IDLE && i_en) begin
            r_shadow <= i_pattern;
            r_guess  <= '0;
            r_len    <= w_len;
            r_cnt    <= '0;
            r_err    <= '0;
            r_timer  <= '0;
            r_eq     <= (w_len == '0);
            r_to     <= 1'b0;
            r_wrong  <= 1'b0;
        end else if (w_acc) begin
            for (int k = 0; k < MAX_LEN; k++)
                if (r_cnt == LEN_W'(k)) r_guess[k*SYM_W +: SYM_W] <= i_in_sym;
            r_cnt   <= r_cnt + 1'b1;
            r_timer <= '0;
            if (!w_match && !r_wrong) begin
                r_wrong <= 1'b1;
                r_err   <= r_cnt;
            end
            // only the closing accept can raise the result; earlier ones leave it 0
            r_eq <= w_last && !r_wrong && w_match;
        end else if (r_state == COLLECT && i_en) begin
            r_timer <= r_timer + 1'b1;
            if (w_tout) r_to <= 1'b1;
        end
    end
    assign o_in_ready       = (r_state == COLLECT) && i_en;
    assign o_received_input = (r_state == DONE);
    assign o_user_guess     = r_guess;
    assign o_guess_cnt      = r_cnt;
    assign o_is_equal       = r_eq;
    assign o_timed_out      = r_to;
    assign o_err_idx        = r_err;
endmodule

// File: tb/tb_sequence_input_collector.sv
// tb_sequence_input_collector: randomized self-checking bench against a behavioural round model
module tb_sequence_input_collector;
    logic        clk = 0, rst_n = 0, en = 0, clr = 0, in_valid = 0;
    logic [3:0]  length = 0;
    logic [15:0] pattern = 0;
    logic [1:0]  in_sym = 0;
    logic        rdy, ri, eq, to, rdy0, ri0, eq0, to0;
    logic [15:0] guess, guess0;
    logic [3:0]  cnt, err, cnt0, err0;
    logic [15:0] pat;
    logic [1:0]  g_sym[12];
    int          total = 0, bad = 0;
    always #5 clk = ~clk;
    sequence_input_collector #(.SYM_W(2), .MAX_LEN(8), .TIMEOUT_CYC(16), .EARLY_ABORT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_length(length), .i_pattern(pattern),
        .i_in_valid(in_valid), .i_in_sym(in_sym), .o_in_ready(rdy), .o_user_guess(guess), .o_guess_cnt(cnt),
        .o_received_input(ri), .o_is_equal(eq), .o_timed_out(to), .o_err_idx(err));
    sequence_input_collector #(.SYM_W(2), .MAX_LEN(8), .TIMEOUT_CYC(16), .EARLY_ABORT(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_length(length), .i_pattern(pattern),
        .i_in_valid(in_valid), .i_in_sym(in_sym), .o_in_ready(rdy0), .o_user_guess(guess0), .o_guess_cnt(cnt0),
        .o_received_input(ri0), .o_is_equal(eq0), .o_timed_out(to0), .o_err_idx(err0));
    task automatic do_round(input int len, input int gapmax, input bit keep_en);
        int eff = (len > 8) ? 8 : len;
        int ecnt = 0, eerr = 0, eerr0 = 0;
        bit w = 0, w0 = 0;
        logic [15:0] eg = 0, eg0 = 0;
        for (int i = 0; i < eff; i++) begin
            eg0[i*2 +: 2] = g_sym[i];
            if (g_sym[i] !== pat[i*2 +: 2] && !w0) begin w0 = 1; eerr0 = i; end
            if (!w) begin
                ecnt++;
                eg[i*2 +: 2] = g_sym[i];
                if (g_sym[i] !== pat[i*2 +: 2]) begin w = 1; eerr = i; end
            end
        end
        @(negedge clk); en = 1; length = 4'(len); pattern = pat;
        @(negedge clk); pattern = 16'($urandom); length = 4'($urandom);
        total++;
        if (eff == 0 ? {ri, eq, cnt, ri0, eq0} !== {2'b11, 4'd0, 2'b11} : {rdy, ri} !== 2'b10) begin
            bad++; $display("FAIL start len=%0d got rdy=%b ri=%b eq=%b cnt=%0d ri0=%b", len, rdy, ri, eq, cnt, ri0);
        end
        for (int i = 0; i < eff; i++) begin
            repeat ($urandom_range(gapmax, 0)) @(negedge clk);
            in_valid = 1; in_sym = g_sym[i];
            @(negedge clk); in_valid = 0;
            if (i + 1 == ecnt) begin
                total++;
                if ({ri, eq, to, cnt, err, guess} !== {1'b1, 1'(!w), 1'b0, 4'(ecnt), 4'(eerr), eg}) begin
                    bad++; $display("FAIL result_ea got ri=%b eq=%b to=%b cnt=%0d err=%0d guess=%h exp eq=%b cnt=%0d err=%0d guess=%h",
                                    ri, eq, to, cnt, err, guess, !w, ecnt, eerr, eg);
                end
            end else if (i + 1 < ecnt) begin
                total++;
                if (ri !== 1'b0) begin bad++; $display("FAIL early_pulse idx=%0d got ri=%b exp 0", i, ri); end
            end
            if (i + 1 == eff) begin
                total++;
                if ({ri0, eq0, cnt0, err0, guess0} !== {1'b1, 1'(!w0), 4'(eff), 4'(eerr0), eg0}) begin
                    bad++; $display("FAIL result_full got ri=%b eq=%b cnt=%0d err=%0d guess=%h exp eq=%b cnt=%0d err=%0d guess=%h",
                                    ri0, eq0, cnt0, err0, guess0, !w0, eff, eerr0, eg0);
                end
            end
        end
        @(negedge clk);
        total++;
        if ({ri, ri0, rdy, rdy0, eq, cnt, guess} !== {4'b0, 1'(!w), 4'(ecnt), eg}) begin
            bad++; $display("FAIL hold got ri=%b ri0=%b rdy=%b eq=%b cnt=%0d guess=%h exp eq=%b cnt=%0d guess=%h",
                            ri, ri0, rdy, eq, cnt, guess, !w, ecnt, eg);
        end
        if (!keep_en) begin en = 0; @(negedge clk); end
    endtask
    task automatic test_reset;
        #2;
        total++;
        if ({rdy, ri, eq, to, err, cnt, guess} !== '0) begin bad++; $display("FAIL reset got nonzero outputs cnt=%0d guess=%h", cnt, guess); end
        @(negedge clk); rst_n = 1; @(negedge clk);
    endtask
    task automatic test_match;
        pat = 16'h0032; g_sym[0] = 2; g_sym[1] = 0; g_sym[2] = 3;
        do_round(3, 0, 0);
        total++;
        if (guess[5:0] !== 6'b11_00_10) begin bad++; $display("FAIL packing got=%b exp=110010", guess[5:0]); end
    endtask
    task automatic test_mismatch;
        pat = 16'h0032; g_sym[0] = 2; g_sym[1] = 1; g_sym[2] = 3;
        do_round(3, 0, 0);
    endtask
    task automatic test_lengths;
        pat = 16'($urandom);
        for (int i = 0; i < 8; i++) g_sym[i] = pat[i*2 +: 2];
        do_round(0, 0, 0);
        do_round(12, 1, 0);
    endtask
    task automatic test_timeout;
        int n = 0;
        pat = 16'h0032;
        @(negedge clk); en = 1; length = 2; pattern = pat;
        @(negedge clk); in_valid = 1; in_sym = 2;
        @(negedge clk); in_valid = 0;
        while (ri !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        total++;
        if (n != 16 || {to, eq, cnt, err, ri0, to0} !== {1'b1, 1'b0, 4'd1, 4'd0, 2'b11}) begin
            bad++; $display("FAIL timeout got delay=%0d to=%b eq=%b cnt=%0d err=%0d ri0=%b exp delay=16 to=1 cnt=1", n, to, eq, cnt, err, ri0);
        end
        en = 0; @(negedge clk);
    endtask
    task automatic test_back_to_back;
        int stuck = 0;
        pat = 16'h00e4;
        for (int i = 0; i < 3; i++) g_sym[i] = pat[i*2 +: 2];
        do_round(3, 0, 1);
        repeat (5) begin
            @(negedge clk);
            if (ri !== 1'b0 || rdy !== 1'b0) stuck++;
        end
        total++;
        if (stuck != 0) begin bad++; $display("FAIL en_held got %0d cycles with pulse/ready exp 0", stuck); end
        en = 0; @(negedge clk);
        en = 1; length = 2; @(negedge clk);
        total++;
        if ({rdy, ri, eq, to, cnt, err, guess} !== {1'b1, 27'd0}) begin
            bad++; $display("FAIL restart got rdy=%b ri=%b eq=%b cnt=%0d guess=%h exp rdy=1 rest 0", rdy, ri, eq, cnt, guess);
        end
        en = 0; @(negedge clk);
    endtask
    task automatic test_clr_rst;
        @(negedge clk); en = 1; length = 4; pattern = 16'h00ff;
        @(negedge clk); in_valid = 1; in_sym = 3;
        @(negedge clk); @(negedge clk);
        clr = 1; en = 0; in_valid = 0;
        @(negedge clk);
        total++;
        if ({rdy, ri, eq, to, err, cnt, guess} !== '0) begin bad++; $display("FAIL clr got cnt=%0d guess=%h exp 0", cnt, guess); end
        clr = 0; in_valid = 1;
        repeat (3) @(negedge clk);
        in_valid = 0;
        total++;
        if ({rdy, ri, cnt, guess} !== '0) begin bad++; $display("FAIL ignore got rdy=%b cnt=%0d guess=%h exp 0", rdy, cnt, guess); end
        en = 1; @(negedge clk); in_valid = 1; in_sym = 1;
        @(negedge clk); in_valid = 0;
        rst_n = 0; #1;
        total++;
        if ({rdy, ri, eq, to, err, cnt, guess} !== '0) begin bad++; $display("FAIL async_rst got cnt=%0d guess=%h exp 0", cnt, guess); end
        en = 0; @(negedge clk); rst_n = 1; @(negedge clk);
    endtask
    task automatic test_random;
        for (int r = 0; r < 30; r++) begin
            pat = 16'($urandom);
            for (int i = 0; i < 12; i++)
                g_sym[i] = (i >= 8 || $urandom_range(3, 0) == 0) ? 2'($urandom) : pat[i*2 +: 2];
            do_round(int'($urandom_range(12, 0)), 3, 0);
        end
    endtask
    initial begin
        test_reset;
        test_match;
        test_mismatch;
        test_lengths;
        test_timeout;
        test_back_to_back;
        test_clr_rst;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sequence_input_collector.md
# sequence_input_collector

Parametrised successor to the game's single-bit input handler. It collects a round's worth of multi-bit player symbols, such as 1 bit for the classic two-button mode or 2 bits for a four-button mode. It compares each symbol against a latched copy of the game pattern as it arrives, aborts early on the first mismatch, and enforces an inactivity timeout. It sits between the mode FSM (en/clr, received_input/is_equal) and the pattern shift register / score counter, and replaces the separate handler + comparator pair.

## Interface
- SYM_W, 1: bits per symbol (1 = classic binary mode)
- MAX_LEN, 32: maximum symbols per round; pattern/guess storage depth
- TIMEOUT_CYC, 1024: idle cycles allowed between symbols; 0 disables timeout
- EARLY_ABORT, 1: 1 = finish on first wrong symbol; 0 = collect full length, then judge
- LEN_W, $clog2(MAX_LEN+1): derived width of length/count ports
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  input phase granted by mode FSM (level)
- clr  in  1  synchronous clear of all state and results
- length  in  LEN_W  symbols expected this round (score count), sampled at round start
- pattern  in  MAX_LEN*SYM_W  game pattern; symbol i at [i*SYM_W +: SYM_W], symbol 0 first
- in_valid  in  1  player symbol present this cycle
- in_sym  in  SYM_W  player symbol
- in_ready  out  1  symbol accepted when in_valid && in_ready
- user_guess  out  MAX_LEN*SYM_W  captured symbols, same packing as pattern; unused slots 0
- guess_cnt  out  LEN_W  symbols accepted this round
- received_input  out  1  one-cycle pulse: round finished
- is_equal  out  1  result: all expected symbols matched
- timed_out  out  1  result: round ended by timeout
- err_idx  out  LEN_W  index of first wrong symbol (0 if none)

## Operation
- States: IDLE, COLLECT, DONE, HOLD.
- IDLE: in_ready=0. On en=1, the block does the following and enters COLLECT:
  - latch pattern into a shadow register
  - latch len = min(length, MAX_LEN)
  - clear user_guess, guess_cnt, is_equal, timed_out, err_idx and the timer
- If len==0 at start: go directly to DONE with is_equal=1.
- COLLECT: in_ready=1. On accept:
  - user_guess[guess_cnt] <= in_sym; guess_cnt++
  - compare with shadow[guess_cnt]; on first mismatch record err_idx and set a sticky wrong flag
  - EARLY_ABORT=1 and mismatch: go to DONE with is_equal=0
  - otherwise, when guess_cnt+1==len: go to DONE with is_equal = !wrong && symbol matches
- Timer: counts cycles in COLLECT without an accept; reset to 0 on each accept.
  - When timer reaches TIMEOUT_CYC-1 with no accept: DONE, timed_out=1, is_equal=0.
  - An accept in that same cycle wins over the timeout.
- en falling in COLLECT: return to IDLE silently (no pulse); results stay cleared/partial.
- DONE: received_input=1 for exactly this one cycle, then HOLD.
- HOLD: results held stable. Go to IDLE when en==0. No new round starts while en stays high.
- in_valid outside COLLECT is ignored.
- clr (any state): IDLE, all outputs and storage zeroed. clr has priority over en and in_valid.
- Asynchronous reset: same values as clr, applied immediately.

## Timing
- Reset/clr values: every output 0, including in_ready=0 and received_input=0.
- en sampled high at edge t0 gives in_ready=1 from t0 onward; the first symbol can be accepted at edge t0+1.
- Final accept at edge t gives received_input=1 during cycle t..t+1. is_equal, timed_out, err_idx, guess_cnt and user_guess are valid in that same cycle and hold until the next round start or clr.
- Changes to pattern/length after round start have no effect on the current round.
- One accept per cycle maximum; back-to-back accepts are allowed every cycle.

## Test plan
- SYM_W=2, MAX_LEN=8, length=3, pattern symbols {2,0,3}; send 2,0,3 back-to-back -> received_input pulses one cycle after 3rd accept, is_equal=1, guess_cnt=3, user_guess[5:0]=6'b11_00_10.
- Same round, send 2,1 -> pulse after 2nd accept, is_equal=0, err_idx=1, guess_cnt=2; with EARLY_ABORT=0 the block waits for the 3rd symbol, then is_equal=0, err_idx=1.
- TIMEOUT_CYC=16, length=2; send one correct symbol, then idle -> pulse 16 cycles after the accept, timed_out=1, is_equal=0, guess_cnt=1.
- length=0 -> pulse the cycle after start, is_equal=1. length=12 with MAX_LEN=8 -> round ends after 8 symbols.
- en held high after the pulse -> no second pulse, in_ready=0. Drop en then raise it -> new round, outputs cleared.
- Assert clr mid-COLLECT (and rst_n low mid-round) -> all outputs 0 next edge (immediately for rst_n); a later in_valid is ignored until en restarts a round.
